// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
//   div_state_t : sequencer FSM states
//   F3_*        : Funct3 encodings of the divide-class M-extension ops
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
//   rem_acc   : partial remainder (WIDTH+1 bits)
//   quot      : dividend bits still to shift in / quotient bits shifted out
//   divisor   : divisor magnitude
//   rem_next  : partial remainder after the step
//   quot_next : quotient/dividend register after the step
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_acc,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_acc[WIDTH-1:0], quot[WIDTH-1]};
    // One extra bit so the borrow of the trial subtraction is visible.
    trial   = {1'b0, shifted} - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_next  = trial[WIDTH:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_next  = shifted;
      quot_next = {quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the EX stage.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : EX presents a divide-class op this cycle
//   Funct3     : instruction bits 14:12 selecting the op
//   op_a, op_b : dividend (rs1), divisor (rs2)
//   flush      : kill any in-flight op
//   stall      : freeze IF/ID/EX while the op runs
//   done       : one-cycle pulse, result valid
//   result     : quotient or remainder, held until the next done
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  import div_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH:0]   rem_acc;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] divisor;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] min_neg;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quot;
  logic [WIDTH-1:0] fin_rem;
  logic [WIDTH-1:0] fin_quot;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_acc  (rem_acc),
    .quot     (quot),
    .divisor  (divisor),
    .rem_next (step_rem),
    .quot_next(step_quot)
  );

  always_comb begin
    sgn      = ~Funct3[0];
    a_neg    = sgn & op_a[WIDTH-1];
    b_neg    = sgn & op_b[WIDTH-1];
    abs_a    = a_neg ? (~op_a + 1'b1) : op_a;
    abs_b    = b_neg ? (~op_b + 1'b1) : op_b;
    min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    div_zero = (op_b == '0);
    overflow = sgn && (op_a == min_neg) && (op_b == '1);
    accept   = ~reset & ~flush & start & Funct3[2] & (state == IDLE);
    stall    = ~reset & (accept | (state == BUSY));
    // Final sign fix-up uses the outputs of the last step directly so the
    // result is registered on the same edge that enters DONE.
    fin_rem  = neg_r ? (~step_rem[WIDTH-1:0] + 1'b1) : step_rem[WIDTH-1:0];
    fin_quot = neg_q ? (~step_quot + 1'b1) : step_quot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      rem_acc <= '0;
      quot    <= '0;
      divisor <= '0;
      is_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_rem  <= Funct3[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            divisor <= abs_b;
            quot    <= abs_a;
            rem_acc <= '0;
            counter <= CNT_W'(WIDTH - 1);
            if (div_zero || overflow) begin
              if (div_zero)
                result <= Funct3[1] ? op_a : '1;
              else
                result <= Funct3[1] ? '0 : min_neg;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            rem_acc <= step_rem;
            quot    <= step_quot;
            counter <= counter - 1'b1;
            if (counter == '0) begin
              result <= is_rem ? fin_rem : fin_quot;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;

  import div_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  div_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Funct3(funct3),
    .op_a  (op_a),
    .op_b  (op_b),
    .flush (flush),
    .stall (stall),
    .done  (done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one op at cycle 0 and follows it to its done pulse.
  // junk: keep start high with a different op while the first one runs.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat,
                        input bit junk);
    int lat;
    int nstall;
    lat    = -1;
    nstall = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    #1 if (stall) nstall++;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (junk) begin
        start = 1'b1; funct3 = F3_DIV; op_a = 32'd1; op_b = 32'd1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done) begin
        lat = c;
        break;
      end
      if (stall) nstall++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " stall on done"}, {31'd0, stall}, 32'd0);
    chk({tag, " stall cycles"}, nstall, exp_lat);
    chk({tag, " result"}, result, exp);
    start = 1'b0;
    @(negedge clk);
    #1 chk({tag, " done width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    reset = 1'b0;

    // Main function and sign handling
    run_op("divu 100/7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("rem -100/7", F3_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33, 1'b0);
    run_op("div -100/7", F3_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33, 1'b0);
    run_op("div 7/-2", F3_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b0);
    run_op("rem 7/-2", F3_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33, 1'b0);
    run_op("divu max/1", F3_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 1'b0);
    run_op("remu max/10", F3_REMU, 32'hFFFFFFFF, 32'd10, 32'd5, 33, 1'b0);

    // Special cases resolve on accept
    run_op("div 5/0", F3_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run_op("remu 5/0", F3_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("div ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run_op("rem ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);

    // Flush at cycle 10 of a running op; last result was 0
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    #1 chk("flush stall c10", {31'd0, stall}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush stall c11", {31'd0, stall}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1 if (done || stall) ndone++;
    end
    chk("flush no done/stall", ndone, 0);
    chk("flush result kept", result, 32'd0);

    // Reset at cycle 5 of a running op
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1 chk("midop reset stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("midop reset done", {31'd0, done}, 32'd0);
    chk("midop reset result", result, 32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1 if (done) ndone++;
    end
    chk("reset no done", ndone, 0);
    run_op("remu 10/3", F3_REMU, 32'd10, 32'd3, 32'd1, 33, 1'b0);

    // Non-divide Funct3 is ignored
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd3;
    #1 chk("f3=000 stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("f3=000 no busy", {31'd0, stall}, 32'd0);
    chk("f3=000 no done", {31'd0, done}, 32'd0);

    // Start held while busy and in DONE must not disturb the op
    run_op("divu busy start", F3_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and iterative datapath for RV32M division ops DIV, DIVU, REM and REMU in the EX stage.
- Accepts an operation from EX, stalls the pipeline while it runs a restoring shift-subtract loop, then presents the result for exactly one cycle.
- Sits beside the ALU. Writeback selects its result when done=1.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  EX holds a valid M-extension divide-class op this cycle
- Funct3  input  3  instruction bits 14:12: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  WIDTH  dividend (rs1)
- op_b  input  WIDTH  divisor (rs2)
- flush  input  1  kill in-flight op (branch/jump redirect)
- stall  output  1  freeze IF/ID/EX pipeline registers
- done  output  1  result valid this cycle (single-cycle pulse)
- result  output  WIDTH  quotient or remainder

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, counter=0, result=0, done=0; internal registers cleared.
  - stall=0 while reset=1.
- Reset mid-operation aborts the op; no done pulse follows.
- States: IDLE, BUSY, DONE.
- Accept condition: start=1 and Funct3[2]=1 in IDLE. Accept is ignored when Funct3[2]=0, when not in IDLE, and when flush=1 in the same cycle.
- stall is combinational: (IDLE and accept) or BUSY. It is 0 in DONE, so the pipeline advances on the done cycle.
- On accept, latch the following:
  - signed flag = ~Funct3[0]
  - rem flag = Funct3[1]
  - |op_a| and |op_b| when signed, else raw values
  - neg_q = sign(a) xor sign(b), signed only
  - neg_r = sign(a), signed only
- Special cases, resolved on accept; go IDLE->DONE (done one cycle after accept, stall high for the accept cycle only):
  - op_b==0: quotient = all ones, remainder = op_a.
  - Signed op with op_a==0x80000000 and op_b==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Normal path, IDLE->BUSY:
  - Set counter=WIDTH-1, rem_acc=0 (WIDTH+1 bits), quot=|a|.
- Each BUSY cycle performs one restoring step:
  - shift {rem_acc,quot} left 1
  - trial = rem_acc - |b|
  - if trial is non-negative: rem_acc=trial, quot LSB=1; else quot LSB=0
  - decrement counter
- After the step with counter==0, go to DONE.
- Exactly WIDTH BUSY cycles: accept at cycle 0, done at cycle WIDTH+1 (33).
- DONE:
  - result = rem flag ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot), registered on entry to DONE.
  - done=1 for one cycle, then IDLE.
  - result holds its value until the next DONE.
- A start in DONE is not accepted. The pipeline advances in DONE, so a back-to-back op arrives at the next IDLE cycle.
- flush:
  - In any state, next state is IDLE, done=0 next cycle, stall=0 from the next cycle, and result is unchanged.
  - A flush in the DONE cycle does not suppress that cycle's done.
- All arithmetic is unsigned on magnitudes. Negation is two's complement modulo 2^WIDTH.

Decomposition:
- Package div_pkg:
  - state enum div_state_t {IDLE, BUSY, DONE}
  - Funct3 constants F3_DIV=3'b100, F3_DIVU=3'b101, F3_REM=3'b110, F3_REMU=3'b111
- Sub-module div_step: combinational single restoring iteration.
  - In: rem_acc, quot, divisor.
  - Out: next rem_acc, next quot.
  - Unit-testable alone.
- FSM, counter, sign handling and special-case detection stay in div_sequencer.

Test Plan:
1. DIVU, op_a=100, op_b=7, start at cycle 0 -> stall=1 for cycles 0..32, done=1 at cycle 33, result=14; stall=0 at cycle 33.
2. REM, op_a=-100 (0xFFFFFF9C), op_b=7 -> result=0xFFFFFFFE (-2). DIV with the same operands -> result=0xFFFFFFF2 (-14).
3. DIV, op_a=5, op_b=0 -> done at cycle 1, result=0xFFFFFFFF. REMU with the same operands -> result=5. DIV with 0x80000000 / 0xFFFFFFFF -> result=0x80000000, done at cycle 1.
4. DIVU 100/7 started, flush=1 at cycle 10 -> IDLE at cycle 11, stall=0 from cycle 11, no done pulse, result keeps its previous value.
5. reset=1 at cycle 5 of a busy op -> stall=0 during reset, outputs zero. A new start with REMU 10/3 after reset -> done at +33, result=1.
6. start=1 with Funct3=000, and start=1 asserted while BUSY -> no accept, no stall contribution, the in-flight op completes unchanged.
